branch_predictor: RTL and testbench

- Dynamic branch-direction predictor and resolution stage for the simple_cpu pipeline.
- Decode queries a bimodal history table of 2-bit saturating counters to get a taken/not-taken prediction.
- Execute feeds back the comparator's `branch` flag with the instruction's prediction. The block trains the table, detects mispredicts and issues a registered one-cycle PC redirect/flush to fetch.
- Keeps free-running branch and mispredict counters for performance measurement.

---
 rtl/branch_predictor_pkg.sv | 19 +
 rtl/sat_counter2.sv | 20 ++
 rtl/branch_predictor.sv | 119 +++++++++++
 tb/tb_branch_predictor.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the branch predictor and its neighbours in the fetch path.
package branch_predictor_pkg;

  // 2-bit bimodal counter encodings; bit 1 is the taken prediction.
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Predictor control states.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_e;

  // Sequential fetch increment, also used by the fetch unit.
  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/sat_counter2.sv
// Two-bit saturating up/down counter step: pure combinational next-value function.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       inc,
  output logic [1:0] cnt_nxt
);

  // Step towards ST on taken, towards SNT on not-taken, holding at either end.
  always_comb begin
    cnt_nxt = cnt;
    if (inc) begin
      if (cnt != ST) cnt_nxt = cnt + 2'd1;
    end else begin
      if (cnt != SNT) cnt_nxt = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch-direction predictor with execute-stage resolution, redirect and perf counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] INIT_CNT    = WNT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  output logic        pred_taken,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_pred_taken,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BHT_ENTRIES - 1);

  bp_state_e        state;
  logic [IDX_W-1:0] init_ptr;
  logic             busy_r;

  logic [1:0]       bht [BHT_ENTRIES];

  logic [IDX_W-1:0] id_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             accepted;
  logic             mispredict;
  logic             train_en;
  logic [1:0]       ex_cnt;
  logic [1:0]       ex_cnt_nxt;
  logic             unused_pc_bits;

  // Word-aligned PCs: the two low bits never distinguish branches.
  assign id_idx = id_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{id_pc[31:IDX_W+2], id_pc[1:0]};

  // A branch in execute while a redirect is leaving is on the wrong path and is dropped.
  assign accepted   = ex_valid & ~redirect_valid;
  assign mispredict = accepted & (ex_taken != ex_pred_taken);
  assign train_en   = accepted & (state == RUN);

  // Asynchronous read; a same-cycle write to this index becomes visible next cycle.
  assign pred_taken = id_valid & ~busy_r & bht[id_idx][1];
  assign busy       = busy_r;

  assign ex_cnt = bht[ex_idx];

  sat_counter2 u_sat (
    .cnt     (ex_cnt),
    .inc     (ex_taken),
    .cnt_nxt (ex_cnt_nxt)
  );

  // Table storage: sweep-initialised after reset, then trained by resolved branches.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      bht[init_ptr] <= INIT_CNT;
    end else if (train_en) begin
      bht[ex_idx] <= ex_cnt_nxt;
    end
  end

  // Init sweep FSM: one entry per cycle, then RUN until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_ptr <= '0;
      busy_r   <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == LAST_IDX) begin
            state  <= RUN;
            busy_r <= 1'b0;
          end
        end
        RUN: begin
          busy_r <= 1'b0;
        end
        default: begin
          state  <= INIT;
          busy_r <= 1'b1;
        end
      endcase
    end
  end

  // Registered one-cycle redirect to fetch and the free-running perf counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      redirect_valid <= mispredict;
      if (mispredict) begin
        redirect_pc      <= ex_taken ? ex_target : ex_pc + PC_INC;
        mispredict_count <= mispredict_count + 32'd1;
      end
      if (accepted) begin
        branch_count <= branch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomised and directed bench for branch_predictor against a behavioural reference model.
module tb_branch_predictor;

  localparam int N = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  int          m_cnt [N];
  int          m_init_left;
  bit          m_rv;
  logic [31:0] m_rpc;
  logic [31:0] m_bc;
  logic [31:0] m_mc;

  always #5 clk = ~clk;

  branch_predictor #(.BHT_ENTRIES(N)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_valid         (id_valid),
    .id_pc            (id_pc),
    .pred_taken       (pred_taken),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_pred_taken    (ex_pred_taken),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .busy             (busy),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic bit m_busy();
    return m_init_left > 0;
  endfunction

  task automatic model_reset();
    m_init_left = N;
    m_rv  = 1'b0;
    m_rpc = 32'h0;
    m_bc  = 32'h0;
    m_mc  = 32'h0;
    for (int i = 0; i < N; i++) m_cnt[i] = 1;
  endtask

  task automatic check_regs(input string where);
    chk({where, ".redirect_valid"}, {31'b0, redirect_valid}, {31'b0, m_rv});
    chk({where, ".redirect_pc"}, redirect_pc, m_rpc);
    chk({where, ".busy"}, {31'b0, busy}, {31'b0, m_busy()});
    chk({where, ".branch_count"}, branch_count, m_bc);
    chk({where, ".mispredict_count"}, mispredict_count, m_mc);
  endtask

  // One clock cycle: called at posedge+1, applies inputs, checks the
  // combinational prediction, steps the model at the edge, checks registers.
  task automatic cycle(input bit iv, input logic [31:0] ipc,
                       input bit ev, input logic [31:0] epc, input bit ept,
                       input bit et, input logic [31:0] etgt, input string tag);
    bit acc, mp, exp_pred;
    id_valid = iv; id_pc = ipc;
    ex_valid = ev; ex_pc = epc; ex_pred_taken = ept; ex_taken = et; ex_target = etgt;
    #1;
    exp_pred = iv && !m_busy() && (m_cnt[idx_of(ipc)] >= 2);
    chk({tag, ".pred_taken"}, {31'b0, pred_taken}, {31'b0, exp_pred});
    @(posedge clk);
    acc = ev && !m_rv;
    mp  = acc && (et != ept);
    if (acc && !m_busy()) begin
      if (et) m_cnt[idx_of(epc)] = (m_cnt[idx_of(epc)] + 1 > 3) ? 3 : m_cnt[idx_of(epc)] + 1;
      else    m_cnt[idx_of(epc)] = (m_cnt[idx_of(epc)] - 1 < 0) ? 0 : m_cnt[idx_of(epc)] - 1;
    end
    if (mp) begin
      m_rpc = et ? etgt : epc + 32'd4;
      m_mc  = m_mc + 32'd1;
    end
    if (acc) m_bc = m_bc + 32'd1;
    m_rv = mp;
    if (m_init_left > 0) m_init_left--;
    #1;
    check_regs(tag);
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, tag);
  endtask

  task automatic rand_cycle(input string tag);
    logic [31:0] ipc, epc;
    ipc = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_03FC);
    epc = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_03FC);
    cycle(1'($urandom), ipc, ($urandom_range(0, 3) != 0), epc,
          1'($urandom), 1'($urandom), $urandom, tag);
  endtask

  task automatic do_reset_release();
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b0; id_pc = '0;
    ex_valid = 1'b0; ex_pc = '0; ex_pred_taken = 1'b0; ex_taken = 1'b0; ex_target = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_regs("reset");
    do_reset_release();

    // Init sweep with an idle pipe; pred must stay low even when queried.
    for (int i = 0; i < N; i++)
      cycle(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "init");
    cycle(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "post_init_wnt");

    // Training up to saturation and one step back.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b1, 32'h40, "train_up");
    cycle(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 32'h40, "train_dn");
    cycle(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "after_dn");

    // Taken mispredict, then a wrong-path mispredicting branch in the redirect cycle.
    cycle(1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 1'b1, 32'h180, "mp_taken");
    cycle(1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 1'b0, 32'h500, "wrong_path");
    cycle(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "wp_entry");

    // Not-taken mispredict at the top of the address space.
    cycle(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h1234, "mp_wrap");
    idle("wrap_end");

    // Aliased read/write in the same cycle: pred shows the old value.
    cycle(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0, "alias_a");
    cycle(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0, "alias_b");
    cycle(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "alias_c");

    for (int i = 0; i < 400; i++) rand_cycle("rand");

    // Reset in the middle of a redirect pulse.
    cycle(1'b0, 32'h0, 1'b1, 32'h440, 1'b1, 1'b0, 32'h0, "pre_rst");
    rst_n = 1'b0;
    #1;
    chk("midrst.redirect_valid", {31'b0, redirect_valid}, 32'h0);
    chk("midrst.busy", {31'b0, busy}, 32'h1);
    chk("midrst.redirect_pc", redirect_pc, 32'h0);
    chk("midrst.branch_count", branch_count, 32'h0);
    chk("midrst.mispredict_count", mispredict_count, 32'h0);
    @(posedge clk);
    #1;
    do_reset_release();

    // Second init sweep under random traffic, then more random traffic.
    for (int i = 0; i < N + 300; i++) rand_cycle("rand2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
